tbird_light_sched: RTL and testbench
====================================

Name: tbird_light_sched

Overview:
Controller for the six tail lamps: three left lamps and three right lamps.
- Arbitrates the raw left-turn, right-turn and hazard requests.
- Generates the slow step tick from the system clock with an internal prescaler.
- Sequences the lamp patterns so each blink sequence runs to completion.
- Sits between the driver-switch inputs and the lamp drivers, and replaces direct request-to-state wiring.

Parameters:
- TICK_DIV, 4, clk cycles per sequence step; legal range 1..65535.
- CNT_W, $clog2(TICK_DIV+1), prescaler counter width; derived, never overridden.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- left_req  in  1  left-turn request, level-sensitive.
- right_req  in  1  right-turn request, level-sensitive.
- haz_req  in  1  hazard request, level-sensitive.
- brake  in  1  brake pedal; present only with TBIRD_BRAKE_EN.
- y  out  6  lamp drive. y[5:3] = left lamps LC,LB,LA; y[2:0] = right lamps RA,RB,RC. 1 = lamp on.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high.
- On reset at a clk edge: state=IDLE, prescaler=0, brake_q=0. Then y=6'b000_000 and busy=0. Reset asserted mid-sequence aborts the sequence at that same edge.
- States: IDLE, L1, L2, L3, R1, R2, R3, H_ON, OFF.
- y is a Moore decode of the state register, plus the brake overlay when TBIRD_BRAKE_EN is defined:
  - IDLE=000_000, OFF=000_000
  - L1=001_000, L2=011_000, L3=111_000
  - R1=000_100, R2=000_110, R3=000_111
  - H_ON=111_111
- Prescaler:
  - Held at 0 while in IDLE.
  - In any other state it increments each cycle.
  - step = (count == TICK_DIV-1). On step, count wraps to 0.
- Transitions out of IDLE, evaluated every cycle, priority high to low:
  1. haz_req, or (left_req & right_req) -> H_ON
  2. left_req -> L1
  3. right_req -> R1
  4. otherwise stay in IDLE.
- Transitions in all other states occur only on step:
  - L1->L2->L3->OFF
  - R1->R2->R3->OFF
  - H_ON->OFF
  - OFF->IDLE
- Every non-IDLE state lasts exactly TICK_DIV cycles. IDLE lasts at least 1 cycle between sequences.
- Request inputs are ignored outside IDLE. A sequence is atomic and cannot be redirected mid-flight.
  - Example: switching from left to right during L2 finishes the left sequence, runs OFF, and then starts R1.
- A request held continuously repeats its sequence with a period of:
  - turn: 4*TICK_DIV+1 cycles
  - hazard: 2*TICK_DIV+1 cycles
- TICK_DIV=1: every state lasts 1 cycle; this is legal.
- Request pulses shorter than the IDLE window are lost; no latching is done.

Optional Feature:
TBIRD_BRAKE_EN
- Defined:
  - brake port exists and is registered into brake_q (1-cycle latency).
  - While brake_q=1, all lamps on the side not being sequenced are forced on:
    - L states: y[2:0]=111.
    - R states: y[5:3]=111.
    - IDLE/OFF/H_ON: y=111_111.
  - The overlay is an OR on y only; it never alters state or prescaler timing.
- Undefined: no brake port, no brake_q, and y is the pure state decode.

Decomposition:
- Package tbird_pkg holds:
  - statetype enum logic [3:0]
  - lamp pattern localparams PAT_L1..PAT_L3, PAT_R1..PAT_R3, PAT_HAZ, PAT_OFF
  - BRAKE_SIDE masks 6'b000_111 and 6'b111_000
- One sub-module: tbird_prescaler. Parameter TICK_DIV; inputs clk, reset, clr; output step. The controller drives clr=(state==IDLE).

Test Plan:
1. TICK_DIV=4. Reset, then left_req=1 for one cycle while IDLE -> y=001_000, 011_000, 111_000, 000_000, 4 cycles each; then IDLE with busy=0 after 16 cycles.
2. left_req=1 and right_req=1 together in IDLE -> H_ON y=111_111 for 4 cycles, then OFF 4 cycles. Held for 3 periods -> exactly 3 ON pulses, period 9 cycles.
3. right_req asserted, then at R2 drop right_req and raise left_req -> R2, R3 and OFF complete unchanged (y=000_110, 000_111, 000_000), then L1 starts exactly 1 IDLE cycle later.
4. reset asserted for 1 cycle during L3 -> next edge y=000_000, busy=0, prescaler=0. A held left_req restarts L1 one cycle after reset deasserts, then lasts a full 4 cycles.
5. TICK_DIV=1, haz_req held -> y alternates 111_111, 000_000, 000_000 (H_ON, OFF, IDLE) with a 3-cycle period.
6. TBIRD_BRAKE_EN defined:
   - brake=1 during an L2 sequence -> y=011_111 starting 1 cycle after brake rises.
   - brake=1 in IDLE -> y=111_111.
   - brake toggling during the sequence does not change state-step timing.

Source files
------------

// File: rtl/tbird_pkg.sv
// tbird_pkg: types and constants shared by the tail-lamp sequencer.
//   statetype      : sequencer state encoding
//   PAT_*          : lamp patterns, {LC,LB,LA, RA,RB,RC}
//   BRAKE_SIDE_*   : brake overlay masks for the non-sequenced side
package tbird_pkg;

    typedef enum logic [3:0] {
        IDLE,
        L1,
        L2,
        L3,
        R1,
        R2,
        R3,
        H_ON,
        OFF
    } statetype;

    localparam logic [5:0] PAT_L1  = 6'b001_000;
    localparam logic [5:0] PAT_L2  = 6'b011_000;
    localparam logic [5:0] PAT_L3  = 6'b111_000;
    localparam logic [5:0] PAT_R1  = 6'b000_100;
    localparam logic [5:0] PAT_R2  = 6'b000_110;
    localparam logic [5:0] PAT_R3  = 6'b000_111;
    localparam logic [5:0] PAT_HAZ = 6'b111_111;
    localparam logic [5:0] PAT_OFF = 6'b000_000;

    // Right-side lamps lit while a left sequence runs, and vice versa.
    localparam logic [5:0] BRAKE_SIDE_R = 6'b000_111;
    localparam logic [5:0] BRAKE_SIDE_L = 6'b111_000;

endpackage

// File: rtl/tbird_prescaler.sv
// tbird_prescaler: divides clk down to a one-cycle step pulse every
// TICK_DIV cycles.
//   clk   in  : system clock, rising edge
//   reset in  : synchronous, active-high
//   clr   in  : holds the counter at 0 (sequencer idle)
//   step  out : high on the last cycle of each TICK_DIV-cycle window
module tbird_prescaler #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic step
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // With TICK_DIV=1 step is permanently high; the sequencer ignores it
    // while idle, so no gating by clr is needed.
    assign step = (count_q == LAST);

    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (clr || step) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/tbird_light_sched.sv
// tbird_light_sched: tail-lamp controller for three left and three right
// lamps. Arbitrates left/right/hazard requests while idle and then runs
// the selected blink sequence to completion, one state per prescaler step.
//   clk       in  : system clock, rising edge
//   reset     in  : synchronous, active-high
//   left_req  in  : left-turn request, level
//   right_req in  : right-turn request, level
//   haz_req   in  : hazard request, level
//   brake     in  : brake pedal (only when TBIRD_BRAKE_EN is defined)
//   y[5:0]    out : lamps {LC,LB,LA, RA,RB,RC}, 1 = on
//   busy      out : high whenever a sequence is in progress
// Build option: define TBIRD_BRAKE_EN to add the brake input and overlay.
module tbird_light_sched
    import tbird_pkg::*;
#(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       left_req,
    input  logic       right_req,
    input  logic       haz_req,
`ifdef TBIRD_BRAKE_EN
    input  logic       brake,
`endif
    output logic [5:0] y,
    output logic       busy
);

    statetype state_q;
    statetype state_d;
    logic     step;
    logic [5:0] pattern;

    tbird_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (state_q == IDLE),
        .step  (step)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Requests are only looked at in IDLE; every other state advances on step.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (haz_req || (left_req && right_req)) begin
                    state_d = H_ON;
                end else if (left_req) begin
                    state_d = L1;
                end else if (right_req) begin
                    state_d = R1;
                end
            end
            L1:      if (step) state_d = L2;
            L2:      if (step) state_d = L3;
            L3:      if (step) state_d = OFF;
            R1:      if (step) state_d = R2;
            R2:      if (step) state_d = R3;
            R3:      if (step) state_d = OFF;
            H_ON:    if (step) state_d = OFF;
            OFF:     if (step) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pattern = PAT_OFF;
        case (state_q)
            L1:      pattern = PAT_L1;
            L2:      pattern = PAT_L2;
            L3:      pattern = PAT_L3;
            R1:      pattern = PAT_R1;
            R2:      pattern = PAT_R2;
            R3:      pattern = PAT_R3;
            H_ON:    pattern = PAT_HAZ;
            default: pattern = PAT_OFF;
        endcase
    end

    assign busy = (state_q != IDLE);

`ifdef TBIRD_BRAKE_EN
    logic brake_q;
    logic brake_d;
    logic [5:0] overlay;

    assign brake_d = brake;

    always_ff @(posedge clk) begin
        if (reset) begin
            brake_q <= 1'b0;
        end else begin
            brake_q <= brake_d;
        end
    end

    // Overlay lights the side not being sequenced; outside turn sequences
    // every lamp is lit. Output-only, so state timing is unaffected.
    always_comb begin
        overlay = '0;
        if (brake_q) begin
            case (state_q)
                L1, L2, L3: overlay = BRAKE_SIDE_R;
                R1, R2, R3: overlay = BRAKE_SIDE_L;
                default:    overlay = '1;
            endcase
        end
    end

    assign y = pattern | overlay;
`else
    assign y = pattern;
`endif

endmodule

// File: tb/tb_tbird_light_sched.sv
module tb_tbird_light_sched;

    logic       clk;
    logic       reset;
    logic       left_req;
    logic       right_req;
    logic       haz_req;
    logic       brake;
    logic [5:0] y4;
    logic [5:0] y1;
    logic       busy4;
    logic       busy1;

    int errors;
    int checks;

`ifdef TBIRD_BRAKE_EN
    localparam bit BRAKE_ON = 1'b1;
`else
    localparam bit BRAKE_ON = 1'b0;
`endif

    // DUT index 0: TICK_DIV=4, index 1: TICK_DIV=1; both share the stimulus.
    tbird_light_sched #(
        .TICK_DIV (4)
    ) dut4 (
        .clk       (clk),
        .reset     (reset),
        .left_req  (left_req),
        .right_req (right_req),
        .haz_req   (haz_req),
`ifdef TBIRD_BRAKE_EN
        .brake     (brake),
`endif
        .y         (y4),
        .busy      (busy4)
    );

    tbird_light_sched #(
        .TICK_DIV (1)
    ) dut1 (
        .clk       (clk),
        .reset     (reset),
        .left_req  (left_req),
        .right_req (right_req),
        .haz_req   (haz_req),
`ifdef TBIRD_BRAKE_EN
        .brake     (brake),
`endif
        .y         (y1),
        .busy      (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         unit;
        logic [5:0] y;
        logic       busy;
    } exp_t;

    exp_t sb[$];

    // Reference model: mode 0 idle, 1 left, 2 right, 3 hazard; pos counts
    // cycles since the sequence started.
    int   mode_m[2];
    int   pos_m[2];
    int   td[2];
    logic bq_m;

    function automatic logic [5:0] model_y(int m, int p, int t, logic bk);
        logic [5:0] v;
        int k;
        v = '0;
        k = p / t;
        case (m)
            1: v = (k == 0) ? 6'b001_000 : (k == 1) ? 6'b011_000 :
                   (k == 2) ? 6'b111_000 : 6'b000_000;
            2: v = (k == 0) ? 6'b000_100 : (k == 1) ? 6'b000_110 :
                   (k == 2) ? 6'b000_111 : 6'b000_000;
            3: v = (k == 0) ? 6'b111_111 : 6'b000_000;
            default: v = '0;
        endcase
        if (bk) begin
            if (m == 1 && k < 3)      v = v | 6'b000_111;
            else if (m == 2 && k < 3) v = v | 6'b111_000;
            else                      v = 6'b111_111;
        end
        return v;
    endfunction

    task automatic tick(input logic l, input logic r, input logic h,
                        input logic rst, input logic b);
        exp_t e;
        int   len;
        left_req  = l;
        right_req = r;
        haz_req   = h;
        reset     = rst;
        brake     = b;
        bq_m = rst ? 1'b0 : b;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mode_m[i] = 0;
                pos_m[i]  = 0;
            end else if (mode_m[i] == 0) begin
                pos_m[i] = 0;
                if (h || (l && r)) mode_m[i] = 3;
                else if (l)        mode_m[i] = 1;
                else if (r)        mode_m[i] = 2;
            end else begin
                len = (mode_m[i] == 3) ? 2 * td[i] : 4 * td[i];
                pos_m[i]++;
                if (pos_m[i] == len) begin
                    mode_m[i] = 0;
                    pos_m[i]  = 0;
                end
            end
            e.unit = i;
            e.y    = model_y(mode_m[i], pos_m[i], td[i], bq_m & BRAKE_ON);
            e.busy = (mode_m[i] != 0);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            logic [5:0] oy;
            logic       ob;
            e  = sb.pop_front();
            oy = (e.unit == 0) ? y4 : y1;
            ob = (e.unit == 0) ? busy4 : busy1;
            checks++;
            assert (oy === e.y) else begin
                errors++;
                $error("FAIL y_div%0d t=%0t observed=%b expected=%b",
                       (e.unit == 0) ? 4 : 1, $time, oy, e.y);
            end
            checks++;
            assert (ob === e.busy) else begin
                errors++;
                $error("FAIL busy_div%0d t=%0t observed=%b expected=%b",
                       (e.unit == 0) ? 4 : 1, $time, ob, e.busy);
            end
        end
    endtask

    initial begin
        int   pulses;
        logic prev_on;
        errors = 0;
        checks = 0;
        td[0] = 4;
        td[1] = 1;
        mode_m[0] = 0; mode_m[1] = 0;
        pos_m[0]  = 0; pos_m[1]  = 0;
        bq_m = 1'b0;

        // Reset state
        tick(0, 0, 0, 1, 0);
        tick(0, 0, 0, 1, 0);

        // Single-cycle left pulse: full left sequence, then idle
        tick(1, 0, 0, 0, 0);
        repeat (20) tick(0, 0, 0, 0, 0);

        // Left+right held: hazard, three ON pulses in 27 cycles (period 9)
        pulses  = 0;
        prev_on = 1'b0;
        repeat (27) begin
            tick(1, 1, 0, 0, 0);
            if (y4 == 6'b111_111 && !prev_on) pulses++;
            prev_on = (y4 == 6'b111_111);
        end
        checks++;
        assert (pulses === 3) else begin
            errors++;
            $error("FAIL haz_pulses observed=%0d expected=%0d", pulses, 3);
        end
        repeat (10) tick(0, 0, 0, 0, 0);

        // Right held into R2, then switch to left: right sequence completes
        repeat (5) tick(0, 1, 0, 0, 0);
        repeat (14) tick(1, 0, 0, 0, 0);
        repeat (20) tick(0, 0, 0, 0, 0);

        // Reset during L3 with left held, then restart of L1
        repeat (9) tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 1, 0);
        repeat (6) tick(1, 0, 0, 0, 0);
        repeat (20) tick(0, 0, 0, 0, 0);

        // Hazard held: TICK_DIV=1 unit alternates with a 3-cycle period
        repeat (12) tick(0, 0, 1, 0, 0);
        repeat (12) tick(0, 0, 0, 0, 0);

        // Brake overlay (only visible when the option is built in)
        tick(1, 0, 0, 0, 0);
        repeat (4) tick(0, 0, 0, 0, 0);
        repeat (3) tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0);
        repeat (12) tick(0, 0, 0, 0, 1);
        tick(0, 1, 0, 0, 1);
        repeat (18) tick(0, 0, 0, 0, 0);

        // Random requests
        repeat (60) begin
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 31) == 0),
                 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
